// File: rtl/mem_wb_stage_pkg.sv
// Shared types for the MEM/WB pipeline boundary: decoded instruction fields,
// write-back bundle and the stage FSM states.
package mem_wb_stage_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } wb_state_t;

    typedef struct packed {
        logic        is_load;
        logic        is_store;
        logic        writes_rd;
        logic [4:0]  rd;
    } decoded_inst_t;

    typedef struct packed {
        logic        valid;
        logic        en;
        logic [4:0]  rd;
        logic [63:0] data;
    } wb_bundle_t;

    // Stores finish on write_done, every other memory op on dcache_valid.
    function automatic logic mem_done(decoded_inst_t inst, logic write_done,
                                      logic dcache_valid);
        return inst.is_store ? write_done : dcache_valid;
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM-side bus of the MEM/WB stage: the instruction in MEM, its operands,
// the data-cache completion handshake and the upstream stall.
interface mem_wb_stage_if;
    import mem_wb_stage_pkg::*;

    decoded_inst_t inst;
    logic          is_bubble;
    logic [63:0]   ex_data;
    logic [63:0]   mem_ex_rdata;
    logic          dcache_en;
    logic          dcache_valid;
    logic          write_done;
    logic          mem_stall;

    modport master (
        output inst, is_bubble, ex_data, mem_ex_rdata,
        output dcache_en, dcache_valid, write_done,
        input  mem_stall
    );

    modport slave (
        input  inst, is_bubble, ex_data, mem_ex_rdata,
        input  dcache_en, dcache_valid, write_done,
        output mem_stall
    );

endinterface

// File: rtl/mem_wb_stage_wait_watchdog.sv
// Saturating wait-cycle counter with a sticky timeout flag that stays set
// until reset, even after the counter is cleared for a new wait.
module wait_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_WIDTH       = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic timeout
);

    localparam logic [TO_WIDTH-1:0] Limit = TO_WIDTH'(TIMEOUT_CYCLES);

    logic [TO_WIDTH-1:0] count_q, count_d;
    logic                timeout_q, timeout_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != Limit)) begin
            count_d = count_q + 1'b1;
        end
        timeout_d = timeout_q | (count_d == Limit);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB boundary register: stalls upstream while a data-cache op is pending,
// then registers the register-file write and counts retired instructions.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_WIDTH       = 16
) (
    input  logic         clk,
    input  logic         reset,
    mem_wb_stage_if.slave mem,
    output logic         wb_valid,
    output logic         wb_en,
    output logic [4:0]   wb_rd,
    output logic [63:0]  wb_data,
    output logic [63:0]  instret,
    output logic         mem_timeout
);

    wb_state_t   state_q, state_d;
    wb_bundle_t  wb_q, wb_d;
    logic [63:0] instret_q, instret_d;

    logic memDone;
    logic memStall;
    logic wdClear;
    logic wdInc;

    assign memDone       = mem_done(mem.inst, mem.write_done, mem.dcache_valid);
    assign memStall      = mem.dcache_en && !memDone;
    assign mem.mem_stall = memStall;

    // The FSM only steers the watchdog; capture itself just follows the stall.
    always_comb begin
        state_d = state_q;
        wdClear = 1'b0;
        wdInc   = 1'b0;
        case (state_q)
            IDLE: begin
                if (memStall) begin
                    state_d = WAIT;
                    wdClear = 1'b1;
                end
            end
            WAIT: begin
                if (memStall) begin
                    wdInc = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wb_d       = wb_q;
        wb_d.valid = 1'b0;
        wb_d.en    = 1'b0;
        instret_d  = instret_q;
        if (!memStall) begin
            wb_d.valid = !mem.is_bubble;
            wb_d.en    = !mem.is_bubble && mem.inst.writes_rd &&
                         (mem.inst.rd != 5'd0) && !mem.inst.is_store;
            wb_d.rd    = mem.inst.rd;
            wb_d.data  = mem.inst.is_load ? mem.mem_ex_rdata : mem.ex_data;
            if (!mem.is_bubble) begin
                instret_d = instret_q + 64'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            wb_q      <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wb_q      <= wb_d;
            instret_q <= instret_d;
        end
    end

    wait_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_WIDTH       (TO_WIDTH)
    ) u_wait_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wdClear),
        .inc     (wdInc),
        .timeout (mem_timeout)
    );

    assign wb_valid = wb_q.valid;
    assign wb_en    = wb_q.en;
    assign wb_rd    = wb_q.rd;
    assign wb_data  = wb_q.data;
    assign instret  = instret_q;

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Pipeline stage directly downstream of the memory stage; holds the MEM/WB boundary register.
- Waits for data-cache completion and stalls upstream while a load or store is outstanding.
- Selects the ALU or load result, then drives the register-file write port one cycle later.
- Maintains a retired-instruction counter and a sticky memory-timeout flag.

Parameters:
- TIMEOUT_CYCLES, 1024: consecutive wait cycles after which mem_timeout sets.
- TO_WIDTH, 16: width of the wait counter; must satisfy TIMEOUT_CYCLES < 2^TO_WIDTH.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- inst  in  decoded_inst_t  instruction in MEM; uses fields is_load, is_store, writes_rd, rd[4:0].
- is_bubble  in  1  MEM slot holds no instruction.
- ex_data  in  64  ALU result or effective address from EX.
- mem_ex_rdata  in  64  sign/zero-extended load data from memory stage (combinational).
- dcache_en  in  1  memory op active in MEM this cycle.
- dcache_valid  in  1  load data valid this cycle.
- write_done  in  1  store committed this cycle.
- mem_stall  out  1  combinational; holds all upstream stages (inst/ex_data stable while high).
- wb_valid  out  1  registered; a real instruction retires this cycle.
- wb_en  out  1  registered; register-file write enable.
- wb_rd  out  5  registered destination register.
- wb_data  out  64  registered write data.
- instret  out  64  retired-instruction count.
- mem_timeout  out  1  sticky; set when a wait reaches TIMEOUT_CYCLES.

Behaviour:
- Reset (async, reset==0): state=IDLE; wb_valid=0, wb_en=0, wb_rd=0, wb_data=0, instret=0, mem_timeout=0, wait counter=0. Reset mid-wait abandons the op; no retire.
- done = is_store ? write_done : dcache_valid; evaluated only when dcache_en=1.
- mem_stall = dcache_en && !done (combinational, both states). Non-memory ops and bubbles never stall.
- FSM IDLE: if dcache_en && !done go WAIT, clear wait counter. Otherwise capture this cycle.
- FSM WAIT: stay while !done; counter++ saturating at TIMEOUT_CYCLES. On done, capture and go IDLE.
- Capture (rising edge, stall=0):
  - wb_valid <= !is_bubble.
  - wb_en <= !is_bubble && writes_rd && rd!=0 && !is_store.
  - wb_rd <= rd.
  - wb_data <= is_load ? mem_ex_rdata : ex_data.
- On a stall edge: wb_valid=0 and wb_en=0; wb_rd and wb_data hold previous values.
- Latency:
  - Non-memory op, or memory op done in its first MEM cycle: retires 1 cycle after entering MEM.
  - Memory op with N wait cycles: retires N+1 cycles after entering MEM.
- Load data is sampled only on the done cycle; mem_ex_rdata in earlier wait cycles is ignored.
- instret increments by 1 on each capture with !is_bubble; wraps modulo 2^64.
- mem_timeout sets when the counter reaches TIMEOUT_CYCLES and stays set until reset. The op is not aborted and the stall continues.
- done asserted while dcache_en=0 is ignored.

Decomposition:
- Shared package:
  - wb_state_t enum {IDLE, WAIT}.
  - wb_bundle_t struct {valid, en, rd[4:0], data[63:0]}.
  - decoded_inst_t (existing).
- Sub-module: wait_watchdog holds the saturating counter and sticky flag, with inputs clear/inc.

Test Plan:
- Reset then ADD rd=5, ex_data=0x1234 → next cycle wb_valid=1, wb_en=1, wb_rd=5, wb_data=0x1234; instret=1; mem_stall never high.
- LD rd=7, dcache_valid after 3 wait cycles with mem_ex_rdata=0xFFFF_FFFF_8000_0000 → mem_stall high exactly 3 cycles; wb_data=0xFFFF_FFFF_8000_0000 one cycle after done; no wb_valid during the wait.
- SD with write_done on the same cycle → no stall; wb_valid=1, wb_en=0; instret increments.
- ADDI rd=0, then a bubble → wb_en=0 both cycles; wb_valid=1 then 0; instret +1 only.
- TIMEOUT_CYCLES=8, load never completes → mem_timeout=1 after 8 wait cycles, stall persists. Assert reset mid-wait → all outputs 0, state IDLE, mem_timeout cleared.
- instret preloaded via force to 2^64-1, one ADD retires → instret=0.
